// File: rtl/star_data_feeder_if.sv
// star_data_feeder_if: byte-stream handshake plus consumer read-port bundle
// for star_data_feeder.
//   master : upstream/consumer side (drives bytes, read requests, finish)
//   slave  : the feeder itself
interface star_data_feeder_if #(
  parameter int AW = 9
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          data_req;
  logic [AW-1:0] data_addr;
  logic [7:0]    data;
  logic          finish;
  logic          loaded;
  logic          err;
  logic [7:0]    cksum;

  modport master (
    output in_valid, in_data, data_req, data_addr, finish,
    input  in_ready, data, loaded, err, cksum
  );

  modport slave (
    input  in_valid, in_data, data_req, data_addr, finish,
    output in_ready, data, loaded, err, cksum
  );
endinterface

// File: rtl/star_data_feeder.sv
// star_data_feeder: loads one DEPTH-byte frame from a valid/ready stream into
// a local memory, then serves the consumer's read port with one-cycle
// registered latency until a rising edge of finish re-arms the load.
// Optional feature macro: STAR_FEEDER_CKSUM_EN (mod-256 frame checksum on
// cksum; when undefined cksum is tied to 8'h00).
module star_data_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 9
) (
  input logic               clk,
  input logic               reset,
  star_data_feeder_if.slave bus
);

  localparam int              IW       = $clog2(DEPTH);
  localparam int              LAST     = DEPTH - 1;
  localparam logic [IW-1:0]   LAST_PTR = LAST[IW-1:0];
  localparam logic [IW-1:0]   PTR_ONE  = IW'(1);
  localparam logic [AW:0]     DEPTH_W  = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_e;

  state_e        state_q;
  logic [IW-1:0] wr_ptr_q;
  logic          finish_q;
  logic          in_ready_q;
  logic          loaded_q;
  logic          err_q;
  logic [7:0]    data_q;
  logic [7:0]    mem [DEPTH];

  logic          accept_s;
  logic          finish_rise_s;
  logic          rd_in_range_s;

  // in_ready_q is only ever high in LOAD, so this is exactly the handshake.
  assign accept_s      = (state_q == LOAD) && bus.in_valid && in_ready_q;
  assign finish_rise_s = bus.finish && !finish_q;
  assign rd_in_range_s = ({1'b0, bus.data_addr} < DEPTH_W);

  // Frame control FSM: IDLE -> LOAD -> SERVE -> (finish edge) -> LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      finish_q   <= 1'b0;
      in_ready_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      finish_q <= bus.finish;
      case (state_q)
        IDLE: begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
        end
        LOAD: begin
          if (accept_s) begin
            if (wr_ptr_q == LAST_PTR) begin
              wr_ptr_q   <= '0;
              state_q    <= SERVE;
              in_ready_q <= 1'b0;
              loaded_q   <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
          end
        end
        SERVE: begin
          // A finish level carried over from the previous frame has
          // finish_q already high, so it cannot retrigger here.
          if (finish_rise_s) begin
            state_q    <= LOAD;
            loaded_q   <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wr_ptr_q   <= '0;
          in_ready_q <= 1'b0;
          loaded_q   <= 1'b0;
        end
      endcase
    end
  end

  // Frame memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  // Registered read port with sticky out-of-range error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= 8'h00;
      err_q  <= 1'b0;
    end else if (bus.data_req) begin
      if (state_q == SERVE) begin
        if (rd_in_range_s) begin
          data_q <= mem[bus.data_addr[IW-1:0]];
        end else begin
          data_q <= 8'h00;
          err_q  <= 1'b1;
        end
      end else begin
        data_q <= 8'h00;
      end
    end
  end

`ifdef STAR_FEEDER_CKSUM_EN
  logic [7:0] cksum_q;
  logic       load_entry_s;

  assign load_entry_s = (state_q == IDLE) || ((state_q == SERVE) && finish_rise_s);

  // Running mod-256 sum of the frame; cleared on every entry into LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cksum_q <= 8'h00;
    end else if (load_entry_s) begin
      cksum_q <= 8'h00;
    end else if (accept_s) begin
      cksum_q <= cksum_q + bus.in_data;
    end
  end

  assign bus.cksum = cksum_q;
`else
  assign bus.cksum = 8'h00;
`endif

  assign bus.in_ready = in_ready_q;
  assign bus.loaded   = loaded_q;
  assign bus.err      = err_q;
  assign bus.data     = data_q;

endmodule
